// File: rtl/iobuf_dci_pkg.sv
// Shared definitions for the DCI I/O buffer bank.
//   cal_state_e    : calibration FSM state (IDLE, CAL, LOCK), 2 bits
//   DCI_CODE_W_MAX : widest impedance code the bank supports
//   init_code()    : first SAR trial code (MSB only) for a given code width
package iobuf_dci_pkg;

  localparam int unsigned DCI_CODE_W_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    LOCK = 2'd2
  } cal_state_e;

  function automatic logic [DCI_CODE_W_MAX-1:0] init_code(input int unsigned code_w);
    return DCI_CODE_W_MAX'(1) << (code_w - 1);
  endfunction

endpackage

// File: rtl/iobuf_dci_bank_if.sv
// Bank-side signal bundle for iobuf_dci_bank (pads, clock and reset stay plain ports).
//   GTS, CAL_REQ, DCI_CMP     : global tristate, recal request, reference comparator
//   I, T                      : per-channel output data / tristate control (1 = Z)
//   O                         : registered pad input data
//   DCI_CODE, LOCKED, CAL_BUSY: calibration code and status
// master = driver of the bank (board / system), slave = the bank itself.
interface iobuf_dci_bank_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CODE_W = 5
);
  logic              GTS;
  logic              CAL_REQ;
  logic              DCI_CMP;
  logic [WIDTH-1:0]  I;
  logic [WIDTH-1:0]  T;
  logic [WIDTH-1:0]  O;
  logic [CODE_W-1:0] DCI_CODE;
  logic              LOCKED;
  logic              CAL_BUSY;

  modport master (
    output GTS, CAL_REQ, DCI_CMP, I, T,
    input  O, DCI_CODE, LOCKED, CAL_BUSY
  );

  modport slave (
    input  GTS, CAL_REQ, DCI_CMP, I, T,
    output O, DCI_CODE, LOCKED, CAL_BUSY
  );
endinterface

// File: rtl/iobuf_dci_cal.sv
// Successive-approximation DCI impedance calibration.
//   CLK, RST  : clock, asynchronous active-high reset
//   CAL_REQ   : recalibrate (honoured only while locked)
//   DCI_CMP   : comparator, 1 = current code too low; sampled on the last settle cycle of a bit
//   DCI_CODE  : trial code during calibration, final code once locked
//   LOCKED    : code valid
//   CAL_BUSY  : calibration in progress
module iobuf_dci_cal
  import iobuf_dci_pkg::*;
#(
  parameter int unsigned CODE_W = 5,
  parameter int unsigned SETTLE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CAL_REQ,
  input  logic              DCI_CMP,
  output logic [CODE_W-1:0] DCI_CODE,
  output logic              LOCKED,
  output logic              CAL_BUSY
);

  localparam int unsigned      CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned      IDX_W     = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(init_code(CODE_W));

  cal_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              locked_q, locked_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // LOCKED is a flop one cycle behind entering LOCK, giving CODE_W*SETTLE+1
    // cycles to lock; it drops on the same edge that a recal request is taken.
    locked_d = (state_q == LOCK) && !CAL_REQ;
    unique case (state_q)
      IDLE: begin
        state_d = CAL;
        code_d  = CODE_INIT;
        idx_d   = IDX_MSB;
        cnt_d   = '0;
      end
      CAL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          code_d[idx_q] = DCI_CMP;
          cnt_d         = '0;
          if (idx_q == '0) begin
            state_d = LOCK;
          end else begin
            code_d[idx_q - 1'b1] = 1'b1;
            idx_d                = idx_q - 1'b1;
          end
        end
      end
      LOCK: begin
        if (CAL_REQ) begin
          state_d = CAL;
          code_d  = CODE_INIT;
          idx_d   = IDX_MSB;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DCI_CODE = code_q;
    LOCKED   = locked_q;
    CAL_BUSY = (state_q != IDLE) && !locked_q;
  end

endmodule

// File: rtl/iobuf_dci_bank.sv
// Bank of WIDTH registered bidirectional I/O buffers with DCI calibration.
//   CLK, RST : clock, asynchronous active-high reset
//   IO       : pads (inout)
//   bus      : slave side of iobuf_dci_bank_if (GTS, CAL_REQ, DCI_CMP, I, T, O,
//              DCI_CODE, LOCKED, CAL_BUSY); bus parameters must match WIDTH/CODE_W
// Optional build macro IOBUF_DCI_IN_PIPE2_EN: two-stage input path (O latency 2),
// otherwise a single stage (O latency 1).
module iobuf_dci_bank
  import iobuf_dci_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CODE_W         = 5,
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned FORCE_TS_UNCAL = 1
) (
  input  logic             CLK,
  input  logic             RST,
  inout  wire  [WIDTH-1:0] IO,
  iobuf_dci_bank_if.slave  bus
);

  logic [WIDTH-1:0] i_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] ts;
  logic             locked;

  iobuf_dci_cal #(
    .CODE_W (CODE_W),
    .SETTLE (SETTLE)
  ) u_cal (
    .CLK      (CLK),
    .RST      (RST),
    .CAL_REQ  (bus.CAL_REQ),
    .DCI_CMP  (bus.DCI_CMP),
    .DCI_CODE (bus.DCI_CODE),
    .LOCKED   (locked),
    .CAL_BUSY (bus.CAL_BUSY)
  );

  assign bus.LOCKED = locked;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_q <= '0;
      t_q <= '1;
    end else begin
      i_q <= bus.I;
      t_q <= bus.T;
    end
  end

  // GTS and the uncalibrated force act combinationally on the drivers.
  assign ts = t_q | {WIDTH{bus.GTS}} | {WIDTH{(FORCE_TS_UNCAL != 0) && !locked}};

  for (genvar n = 0; n < WIDTH; n++) begin : g_pad
    assign IO[n] = ts[n] ? 1'bz : i_q[n];
  end

`ifdef IOBUF_DCI_IN_PIPE2_EN
  logic [WIDTH-1:0] in_s1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_s1 <= '0;
      o_q   <= '0;
    end else begin
      in_s1 <= IO;
      o_q   <= in_s1;
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_q <= '0;
    end else begin
      o_q <= IO;
    end
  end
`endif

  assign bus.O = o_q;

endmodule
